candidate_gen: RTL and testbench
================================

CANDIDATE_GEN -- requirements
Module: candidate_gen

Interface
REQ-001 Parameter: WIDTH, 16, candidate bit width; legal range 8..32.
REQ-002 Reset rst, synchronous, active-high; clock clk.
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  single-cycle pulse from the debounced user start button.
REQ-006 rng_in  input  32  free-running pseudo-random word from the 32-bit LFSR.
REQ-007 cand  output  WIDTH  sieved odd candidate, valid while cand_valid=1.
REQ-008 cand_valid  output  1  candidate available.
REQ-009 cand_ready  input  1  downstream (primality tester / key generator) accepts cand.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 attempts  output  8  candidates rejected since last start; saturates at 255.

Function
REQ-012 States SHALL be IDLE, SIEVE, NEXT, DONE; start is honoured only in IDLE.
REQ-013 IDLE: on start=1, the block SHALL load cand <= {1, rng_in[WIDTH-2:1], 1}, clear attempts, set prime index 0, bit index WIDTH-1, remainder r=0, and go to SIEVE.
REQ-014 Sieve primes, in order: 3,5,7,11,13,17,19,23,29,31 (10 entries, 5-bit constants).
REQ-015 SIEVE: each cycle r <= t - p if t >= p else t, where t = 2r + cand[bit index]; bit index SHALL decrement MSB to LSB, one bit per cycle.
REQ-016 On the bit-0 cycle: new r = 0 -> NEXT; else if last prime -> DONE; else advance prime index, bit index <= WIDTH-1, r <= 0, stay in SIEVE.
REQ-017 NEXT (exactly 1 cycle): cand <= cand + 2, except cand = all-ones -> cand <= {1, 0...0, 1}; attempts <= attempts + 1 (saturating); prime index 0, bit index WIDTH-1, r 0; go to SIEVE.
REQ-018 DONE: cand_valid=1, cand held stable; on cand_valid & cand_ready go to IDLE, cand_valid low on the following cycle.
REQ-019 Latency: a candidate passing all primes SHALL raise cand_valid exactly 10*WIDTH cycles after the start-sampling edge; each rejection adds (primes tested)*WIDTH + 1 cycles.
REQ-020 start in any state other than IDLE, including the DONE handshake cycle, SHALL be ignored.
REQ-021 cand SHALL remain unchanged in IDLE after a handshake (last delivered value) until the next start.
REQ-022 cand MSB and LSB SHALL be 1 whenever cand_valid=1.

Reset
REQ-023 rst SHALL force IDLE, cand=0, cand_valid=0, busy=0, attempts=0, r=0, indices 0, from any state on the next clk edge.
REQ-024 rst takes priority over start and cand_ready in the same cycle; a sieve in progress is abandoned with no output.

Verification
REQ-025 WIDTH=16, rng_in=0x00000000, start pulse, cand_ready=1 -> 0x8001 rejected by 3, cand=0x8003, attempts=1, cand_valid rises 177 cycles after start edge.
REQ-026 WIDTH=16, rng_in=0x00007FFE -> loads 0xFFFF, rejected by 3, wraps to 0x8001, rejected, final cand=0x8003, attempts=2.
REQ-027 cand_ready held 0 for 50 cycles in DONE -> cand_valid stays 1, cand constant; ready=1 -> IDLE next cycle, busy=0.
REQ-028 start pulsed again during SIEVE and during DONE -> no reload, result identical to REQ-025.
REQ-029 rst asserted mid-SIEVE -> next cycle all outputs zero, state IDLE; a following start with rng_in=0 repeats REQ-025 exactly.
REQ-030 Random rng_in, 1000 starts -> each cand odd, MSB set, not divisible by any sieve prime, equals first such value at/after load (modulo wrap rule); attempts matches reference model.

Source files
------------

// File: rtl/candidate_gen_if.sv
// -----------------------------------------------------------------------------
// candidate_gen_if
//   Bundles the start/candidate handshake of candidate_gen.
//   start       : one-cycle request pulse (debounced start button)
//   rng_in      : 32-bit free-running LFSR word, sampled on start
//   cand        : sieved odd candidate, valid while cand_valid=1
//   cand_valid  : candidate available
//   cand_ready  : downstream accepts cand
//   busy        : generator not idle
//   attempts    : candidates rejected since last start (saturating)
//   master modport = requester / downstream side, slave modport = generator.
// -----------------------------------------------------------------------------
interface candidate_gen_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [31:0]      rng_in;
    logic [WIDTH-1:0] cand;
    logic             cand_valid;
    logic             cand_ready;
    logic             busy;
    logic [7:0]       attempts;

    modport master (
        output start, rng_in, cand_ready,
        input  cand, cand_valid, busy, attempts
    );

    modport slave (
        input  start, rng_in, cand_ready,
        output cand, cand_valid, busy, attempts
    );
endinterface

// File: rtl/candidate_gen.sv
// -----------------------------------------------------------------------------
// candidate_gen
//   Produces an odd WIDTH-bit candidate with its MSB set that is not divisible
//   by any of the primes 3..31. The start value is taken from rng_in; each
//   rejected candidate is stepped by 2 (all-ones wraps to 1000...0001).
//   Divisibility is tested bit-serially: one candidate bit per cycle, one
//   prime after another, MSB first.
//   Ports:
//     clk  : system clock
//     rst  : synchronous active-high reset
//     bus  : candidate_gen_if.slave (start, rng_in, cand, cand_valid,
//            cand_ready, busy, attempts)
// -----------------------------------------------------------------------------
module candidate_gen #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    candidate_gen_if.slave      bus
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_TOP   = BW'(WIDTH - 1);
    localparam logic [3:0]    LAST_PIDX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        SIEVE,
        NEXT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [7:0]       attempts_q, attempts_d;
    logic [3:0]       pidx_q, pidx_d;
    logic [BW-1:0]    bidx_q, bidx_d;
    logic [4:0]       r_q, r_d;

    logic [5:0]       t;
    logic [5:0]       p;
    logic [4:0]       r_next;

    // rng_in bits outside the candidate body are intentionally dropped.
    logic unused_rng;
    assign unused_rng = ^{bus.rng_in[31:WIDTH-1], bus.rng_in[0]};

    function automatic logic [4:0] prime_at(input logic [3:0] idx);
        logic [4:0] v;
        case (idx)
            4'd0:    v = 5'd3;
            4'd1:    v = 5'd5;
            4'd2:    v = 5'd7;
            4'd3:    v = 5'd11;
            4'd4:    v = 5'd13;
            4'd5:    v = 5'd17;
            4'd6:    v = 5'd19;
            4'd7:    v = 5'd23;
            4'd8:    v = 5'd29;
            default: v = 5'd31;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        attempts_d = attempts_q;
        pidx_d     = pidx_q;
        bidx_d     = bidx_q;
        r_d        = r_q;

        // Shift-and-subtract remainder step; r < p <= 31 so r fits 5 bits.
        t      = {r_q, cand_q[bidx_q]};
        p      = {1'b0, prime_at(pidx_q)};
        r_next = (t >= p) ? 5'(t - p) : t[4:0];

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cand_d     = {1'b1, bus.rng_in[WIDTH-2:1], 1'b1};
                    attempts_d = '0;
                    pidx_d     = '0;
                    bidx_d     = BIT_TOP;
                    r_d        = '0;
                    state_d    = SIEVE;
                end
            end
            SIEVE: begin
                r_d = r_next;
                if (bidx_q == '0) begin
                    if (r_next == 5'd0) begin
                        state_d = NEXT;
                    end else if (pidx_q == LAST_PIDX) begin
                        state_d = DONE;
                    end else begin
                        pidx_d = pidx_q + 4'd1;
                        bidx_d = BIT_TOP;
                        r_d    = '0;
                    end
                end else begin
                    bidx_d = bidx_q - BW'(1);
                end
            end
            NEXT: begin
                if (cand_q == '1) begin
                    cand_d = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
                end else begin
                    cand_d = cand_q + WIDTH'(2);
                end
                if (attempts_q != 8'hFF) begin
                    attempts_d = attempts_q + 8'd1;
                end
                pidx_d  = '0;
                bidx_d  = BIT_TOP;
                r_d     = '0;
                state_d = SIEVE;
            end
            DONE: begin
                if (bus.cand_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cand_q     <= '0;
            attempts_q <= '0;
            pidx_q     <= '0;
            bidx_q     <= '0;
            r_q        <= '0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            attempts_q <= attempts_d;
            pidx_q     <= pidx_d;
            bidx_q     <= bidx_d;
            r_q        <= r_d;
        end
    end

    assign bus.cand       = cand_q;
    assign bus.cand_valid = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.attempts   = attempts_q;

endmodule

// File: tb/tb_candidate_gen.sv
// -----------------------------------------------------------------------------
// tb_candidate_gen
//   Directed bench for candidate_gen at WIDTH=16, plus a short run of random
//   seeds checked against a divisibility/latency reference model.
// -----------------------------------------------------------------------------
module tb_candidate_gen;

    localparam int W = 16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    candidate_gen_if #(.WIDTH(W)) bus ();

    candidate_gen #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start with the given seed and count edges until cand_valid is seen.
    task automatic run(input logic [31:0] rng, output int lat);
        @(negedge clk);
        bus.rng_in = rng;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        lat = 0;
        while (!bus.cand_valid && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Reference: first candidate at/after the load value that no sieve prime
    // divides, with rejection count and cycles to cand_valid.
    function automatic void model(input logic [31:0] rng, output logic [15:0] c,
                                  output int att, output int lat);
        int primes[10] = '{3, 5, 7, 11, 13, 17, 19, 23, 29, 31};
        int k;
        bit found;
        c     = {1'b1, rng[14:1], 1'b1};
        att   = 0;
        lat   = 0;
        found = 0;
        while (!found) begin
            k = -1;
            for (int i = 0; i < 10; i++) begin
                if ((int'(c) % primes[i]) == 0) begin
                    k = i;
                    break;
                end
            end
            if (k < 0) begin
                lat += 10 * W;
                found = 1;
            end else begin
                lat += (k + 1) * W + 1;
                if (att < 255) att++;
                c = (c == 16'hFFFF) ? 16'h8001 : c + 16'd2;
            end
        end
    endfunction

    initial begin
        int lat;
        int bad;
        logic [15:0] mc;
        int matt;
        int mlat;
        logic [31:0] seed;

        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.start     = 1'b1;   // reset must win over start
        bus.rng_in    = '0;
        bus.cand_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy_with_start", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_cand", {16'd0, bus.cand}, 32'd0);
        check("rst_valid", {31'd0, bus.cand_valid}, 32'd0);
        check("rst_attempts", {24'd0, bus.attempts}, 32'd0);
        rst = 1'b0;

        // 0x8001 is 3*10923; 0x8003 survives all primes.
        run(32'h0000_0000, lat);
        check("seed0_latency", lat, 177);
        check("seed0_cand", {16'd0, bus.cand}, 32'h8003);
        check("seed0_attempts", {24'd0, bus.attempts}, 32'd1);
        check("seed0_msb_lsb", {30'd0, bus.cand[15], bus.cand[0]}, 32'd3);
        @(negedge clk);
        check("seed0_valid_drop", {31'd0, bus.cand_valid}, 32'd0);
        check("seed0_idle", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("idle_cand_held", {16'd0, bus.cand}, 32'h8003);

        // 0xFFFF rejected by 3, wraps to 0x8001, rejected by 3, then 0x8003.
        run(32'h0000_7FFE, lat);
        check("wrap_latency", lat, 16 + 1 + 16 + 1 + 160);
        check("wrap_cand", {16'd0, bus.cand}, 32'h8003);
        check("wrap_attempts", {24'd0, bus.attempts}, 32'd2);
        @(negedge clk);

        // Backpressure: hold DONE for 50 cycles.
        bus.cand_ready = 1'b0;
        run(32'h0000_0000, lat);
        check("bp_latency", lat, 177);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.cand_valid !== 1'b1 || bus.cand !== 16'h8003 || bus.busy !== 1'b1) bad++;
        end
        check("bp_hold_bad_cycles", bad, 0);
        bus.cand_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {31'd0, bus.cand_valid}, 32'd0);
        check("bp_release_busy", {31'd0, bus.busy}, 32'd0);

        // start during SIEVE, during DONE and on the handshake cycle is ignored.
        bus.cand_ready = 1'b0;
        @(negedge clk);
        bus.rng_in = 32'h0000_0000;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        lat = 0;
        while (!bus.cand_valid && lat < 5000) begin
            @(negedge clk);
            lat++;
            bus.start = (lat == 20);
            if (lat == 20) bus.rng_in = 32'h0000_7FFE;
        end
        bus.start = 1'b0;
        check("ign_latency", lat, 177);
        check("ign_cand", {16'd0, bus.cand}, 32'h8003);
        check("ign_attempts", {24'd0, bus.attempts}, 32'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("ign_done_valid", {31'd0, bus.cand_valid}, 32'd1);
        check("ign_done_cand", {16'd0, bus.cand}, 32'h8003);
        bus.start      = 1'b1;
        bus.cand_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("ign_hs_busy", {31'd0, bus.busy}, 32'd0);
        check("ign_hs_cand", {16'd0, bus.cand}, 32'h8003);
        @(negedge clk);
        check("ign_hs_busy_after", {31'd0, bus.busy}, 32'd0);

        // Reset mid-sieve abandons the run.
        bus.rng_in = 32'h0000_0000;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_busy_before_rst", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_cand", {16'd0, bus.cand}, 32'd0);
        check("mid_rst_valid", {31'd0, bus.cand_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_attempts", {24'd0, bus.attempts}, 32'd0);
        run(32'h0000_0000, lat);
        check("post_rst_latency", lat, 177);
        check("post_rst_cand", {16'd0, bus.cand}, 32'h8003);
        check("post_rst_attempts", {24'd0, bus.attempts}, 32'd1);
        @(negedge clk);

        // Random seeds against the reference model.
        for (int n = 0; n < 60; n++) begin
            seed = $urandom;
            model(seed, mc, matt, mlat);
            run(seed, lat);
            check("rnd_cand", {16'd0, bus.cand}, {16'd0, mc});
            check("rnd_attempts", {24'd0, bus.attempts}, matt);
            check("rnd_latency", lat, mlat);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
